contador_param: RTL
===================

# contador_param

Parametrised up/down modulo counter with load, wrap or saturate mode, carry/borrow pulses for cascading, and an optional hold-to-repeat state machine for push-button setting. It generalises the 3-bit up/down counter to any width and any terminal value. It sits between debounced user controls and display/time-keeping logic.

## Interface
- WIDTH, 3: counter width in bits, at least 1.
- MAX, 7: terminal count, inclusive; valid range is 1 to 2^WIDTH-1.
- SAT, 0: overflow mode; 0 wraps (MAX→0, 0→MAX), 1 saturates at MAX and at 0.
- REP_EN, 0: 0 steps on every enabled cycle with a direction held; 1 enables the press/hold repeat FSM.
- REP_DELAY, 4: cycles of continuous hold from the first step to the second step, at least 1.
- REP_RATE, 2: cycles between steps once repeating, at least 1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; forces the reset state immediately while low.
- en  in  1  count enable; when low, no steps occur and the FSM returns to IDLE.
- up  in  1  count up request.
- down  in  1  count down request.
- load  in  1  synchronous load of din, independent of en.
- din  in  WIDTH  load value; any value above MAX is clamped to MAX.
- q  out  WIDTH  registered count.
- tc_up  out  1  registered one-cycle carry pulse.
- tc_down  out  1  registered one-cycle borrow pulse.
- at_max  out  1  combinational; high when q == MAX.
- at_zero  out  1  combinational; high when q == 0.

## Operation
- Each cycle, priority is: load, then step, then hold.
- A load sets q to min(din, MAX), puts the FSM in IDLE, and clears tc_up and tc_down.
- A valid request is en=1 with exactly one of up or down high.
  - up=down=1 is treated as no request.
  - Any cycle without a valid request sends the FSM to IDLE.
- A step up works as follows:
  - If q < MAX, q becomes q+1.
  - If q == MAX and SAT=0, q becomes 0 and tc_up=1.
  - If q == MAX and SAT=1, q is held and tc_up=1, which flags the attempted overflow.
- A step down works as follows:
  - If q > 0, q becomes q-1.
  - If q == 0 and SAT=0, q becomes MAX and tc_down=1.
  - If q == 0 and SAT=1, q is held and tc_down=1.
- All comparisons are unsigned at WIDTH bits. Wrapping goes to MAX, not to 2^WIDTH-1.
- REP_EN=0: a step occurs in every cycle with a valid request. The FSM is unused and stays in IDLE.
- REP_EN=1: the FSM has states IDLE, DELAY and REPEAT, a latched direction dir, and a down-counter rc. rc is sized for max(REP_DELAY, REP_RATE).
  - IDLE with a valid request: step once, latch dir, load rc=REP_DELAY-1, go to DELAY.
  - DELAY with the same direction held: if rc==0, step, load rc=REP_RATE-1 and go to REPEAT; otherwise decrement rc.
  - REPEAT with the same direction held: if rc==0, step and reload rc=REP_RATE-1; otherwise decrement rc.
  - DELAY or REPEAT with a valid request in the opposite direction: treat it as a new press. Step immediately in the new direction, latch dir, load rc=REP_DELAY-1, go to DELAY.
  - Request released or en low: go to IDLE with no step.
- tc_up and tc_down are 0 in every cycle that does not meet their condition.
- tc_up and tc_down are never high together.

## Timing
- Reset state: q=0, tc_up=0, tc_down=0, FSM in IDLE, rc=0, dir=up. In this state at_zero=1, and at_max=0 because MAX≥1.
- Release of reset is synchronised by the clock. The first step can occur at the first rising edge after reset goes high.
- Latency:
  - Inputs are sampled at edge k, and q, tc_up and tc_down update at that same edge.
  - Each tc pulse is visible for exactly the cycle after the edge that caused it, together with the new q.
- Repeat timing with REP_EN=1, when a direction is held from edge 0:
  - steps occur at edges 0, REP_DELAY, REP_DELAY+REP_RATE, REP_DELAY+2·REP_RATE, and so on;
  - a one-cycle press gives exactly one step.
- Reset asserted mid-hold: the counter goes to the reset state immediately. If the hold continues after release, it is treated as a new press.
- A load in the same cycle as a request: load wins, and the request is first seen as a new press on the next cycle.

## Test plan
- Reset low mid-count at q=5 → q=0 immediately (asynchronously), tc_up=tc_down=0, at_zero=1.
- WIDTH=4, MAX=9, SAT=0, REP_EN=0, up held 12 cycles from 0 → q goes 1,2,…,9,0,1,2; tc_up=1 only in the cycle where q=0.
- Same parameters, down from q=0 for 2 cycles → q=9 with tc_down=1, then q=8 with tc_down=0. With SAT=1 instead: q stays 0 and tc_down=1 on every attempt.
- REP_EN=1, REP_DELAY=4, REP_RATE=2, up held 10 cycles from q=0 → steps at edges 0,4,6,8, giving q=4 at the end. Then down for 1 cycle → q=3. Then up=down=1 → no change and FSM in IDLE.
- load=1, din=15, MAX=9, while up=1 and en=0 → q=9, at_max=1. Next cycle up with en=1 and SAT=0 → q=0, tc_up=1.
- REP_EN=1, hold up for 5 cycles, then switch to down → down step occurs at the switch edge and the next one REP_DELAY edges later. en=0 during a hold → no steps and IDLE; en=1 again → immediate step.

Source files
------------

// File: rtl/contador_param_if.sv
// -----------------------------------------------------------------------------
// contador_param_if
// Bundle of control and status signals for the contador_param counter.
//
// Parameters:
//   WIDTH    counter width in bits (must match the counter instance)
//
// Signals:
//   en       count enable                     (master -> slave)
//   up       count-up request                 (master -> slave)
//   down     count-down request               (master -> slave)
//   load     synchronous load strobe          (master -> slave)
//   din      load value, clamped to MAX       (master -> slave)
//   q        registered count                 (slave -> master)
//   tc_up    registered one-cycle carry       (slave -> master)
//   tc_down  registered one-cycle borrow      (slave -> master)
//   at_max   q == MAX, combinational          (slave -> master)
//   at_zero  q == 0, combinational            (slave -> master)
//
// Modports:
//   master   the controlling side (button logic, test stimulus)
//   slave    the counter itself
// -----------------------------------------------------------------------------
interface contador_param_if #(
  parameter int WIDTH = 3
);

  logic             en;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc_up;
  logic             tc_down;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en,
    output up,
    output down,
    output load,
    output din,
    input  q,
    input  tc_up,
    input  tc_down,
    input  at_max,
    input  at_zero
  );

  modport slave (
    input  en,
    input  up,
    input  down,
    input  load,
    input  din,
    output q,
    output tc_up,
    output tc_down,
    output at_max,
    output at_zero
  );

endinterface

// File: rtl/contador_param.sv
// -----------------------------------------------------------------------------
// contador_param
// Parametrised up/down modulo counter with synchronous load, wrap or saturate
// behaviour at the terminal values, carry/borrow pulses for cascading and an
// optional press/hold auto-repeat state machine for push-button setting.
//
// Parameters:
//   WIDTH      counter width in bits, >= 1
//   MAX        terminal count (inclusive), 1 .. 2^WIDTH-1
//   SAT        0: wrap MAX->0 and 0->MAX, 1: saturate at MAX and at 0
//   REP_EN     0: step on every cycle with a valid request
//              1: press/hold repeat (first step, pause, then periodic steps)
//   REP_DELAY  hold cycles from the first step to the second step, >= 1
//   REP_RATE   cycles between steps once repeating, >= 1
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        contador_param_if slave modport
//                inputs : en, up, down, load, din
//                outputs: q, tc_up, tc_down (registered),
//                         at_max, at_zero (combinational from q)
//
// Per-cycle priority is load, then step, then hold. A valid request is en=1
// with exactly one of up/down high; up=down=1 counts as no request.
// -----------------------------------------------------------------------------
module contador_param #(
  parameter int WIDTH     = 3,
  parameter int MAX       = 7,
  parameter int SAT       = 0,
  parameter int REP_EN    = 0,
  parameter int REP_DELAY = 4,
  parameter int REP_RATE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  contador_param_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // The repeat counter only ever holds REP_DELAY-1 or REP_RATE-1 at most,
  // so clog2 of the larger of the two is enough bits (minimum one bit).
  localparam int RC_MAXV = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RC_W    = (RC_MAXV > 1) ? $clog2(RC_MAXV) : 1;

  localparam logic [WIDTH-1:0] L_MAX      = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] L_ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONE      = WIDTH'(1);
  localparam logic [RC_W-1:0]  L_RC_DELAY = RC_W'(REP_DELAY - 1);
  localparam logic [RC_W-1:0]  L_RC_RATE  = RC_W'(REP_RATE - 1);
  localparam logic [RC_W-1:0]  L_RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]  L_RC_ONE   = RC_W'(1);

  // Direction encoding for the latched direction: 1 = up, 0 = down.
  localparam logic L_DIR_UP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic               r_dir;
  logic [RC_W-1:0]    r_rc;
  logic [WIDTH-1:0]   r_q;
  logic               r_tc_up;
  logic               r_tc_down;

  state_t             w_state_nxt;
  logic               w_dir_nxt;
  logic [RC_W-1:0]    w_rc_nxt;

  logic               w_req;
  logic               w_req_up;
  logic               w_new_dir;
  logic               w_step;
  logic               w_step_up;

  logic [WIDTH-1:0]   w_din_clamped;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_tc_up_nxt;
  logic               w_tc_down_nxt;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // XOR rejects both the idle case and the up=down=1 conflict in one term.
  assign w_req     = bus.en & (bus.up ^ bus.down);
  assign w_req_up  = bus.up;
  // Opposite direction while holding is handled as a fresh press.
  assign w_new_dir = (w_req_up != r_dir);

  assign w_din_clamped = (bus.din > L_MAX) ? L_MAX : bus.din;

  // ---------------------------------------------------------------------------
  // Repeat FSM
  // ---------------------------------------------------------------------------

  // FSM state, latched direction and repeat down-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dir   <= L_DIR_UP;
      r_rc    <= L_RC_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  // FSM next-state, next direction and next repeat-counter value.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rc_nxt    = r_rc;
    if (REP_EN == 0) begin
      // Repeat logic unused: park in IDLE.
      w_state_nxt = ST_IDLE;
      w_rc_nxt    = L_RC_ZERO;
    end else if (bus.load) begin
      // A load ends any hold; a request in the same cycle is ignored and is
      // seen as a new press on the following cycle.
      w_state_nxt = ST_IDLE;
      w_rc_nxt    = L_RC_ZERO;
    end else if (!w_req) begin
      w_state_nxt = ST_IDLE;
      w_rc_nxt    = L_RC_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DELAY;
          w_dir_nxt   = w_req_up;
          w_rc_nxt    = L_RC_DELAY;
        end
        ST_DELAY: begin
          if (w_new_dir) begin
            w_state_nxt = ST_DELAY;
            w_dir_nxt   = w_req_up;
            w_rc_nxt    = L_RC_DELAY;
          end else if (r_rc == L_RC_ZERO) begin
            w_state_nxt = ST_REPEAT;
            w_rc_nxt    = L_RC_RATE;
          end else begin
            w_state_nxt = ST_DELAY;
            w_rc_nxt    = r_rc - L_RC_ONE;
          end
        end
        ST_REPEAT: begin
          if (w_new_dir) begin
            w_state_nxt = ST_DELAY;
            w_dir_nxt   = w_req_up;
            w_rc_nxt    = L_RC_DELAY;
          end else if (r_rc == L_RC_ZERO) begin
            w_state_nxt = ST_REPEAT;
            w_rc_nxt    = L_RC_RATE;
          end else begin
            w_state_nxt = ST_REPEAT;
            w_rc_nxt    = r_rc - L_RC_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe idle state.
          w_state_nxt = ST_IDLE;
          w_rc_nxt    = L_RC_ZERO;
        end
      endcase
    end
  end

  // FSM output: whether this cycle steps, and in which direction.
  always_comb begin
    w_step    = 1'b0;
    w_step_up = w_req_up;
    if (bus.load) begin
      w_step = 1'b0;
    end else if (!w_req) begin
      w_step = 1'b0;
    end else if (REP_EN == 0) begin
      w_step = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:   w_step = 1'b1;
        ST_DELAY:  w_step = w_new_dir | (r_rc == L_RC_ZERO);
        ST_REPEAT: w_step = w_new_dir | (r_rc == L_RC_ZERO);
        default:   w_step = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Count datapath
  // ---------------------------------------------------------------------------

  // Next count and carry/borrow: load, else step with wrap/saturate, else hold.
  always_comb begin
    w_q_nxt       = r_q;
    w_tc_up_nxt   = 1'b0;
    w_tc_down_nxt = 1'b0;
    if (bus.load) begin
      w_q_nxt = w_din_clamped;
    end else if (w_step) begin
      if (w_step_up) begin
        if (r_q < L_MAX) begin
          w_q_nxt = r_q + L_ONE;
        end else begin
          // At MAX the carry flags the overflow even when saturating.
          w_tc_up_nxt = 1'b1;
          w_q_nxt     = (SAT != 0) ? r_q : L_ZERO;
        end
      end else begin
        if (r_q > L_ZERO) begin
          w_q_nxt = r_q - L_ONE;
        end else begin
          w_tc_down_nxt = 1'b1;
          w_q_nxt       = (SAT != 0) ? r_q : L_MAX;
        end
      end
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Count, carry and borrow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= L_ZERO;
      r_tc_up   <= 1'b0;
      r_tc_down <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_tc_up   <= w_tc_up_nxt;
      r_tc_down <= w_tc_down_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.q       = r_q;
  assign bus.tc_up   = r_tc_up;
  assign bus.tc_down = r_tc_down;
  // Terminal flags are decoded straight from q so cascaded logic sees them
  // in the same cycle as the count.
  assign bus.at_max  = (r_q == L_MAX);
  assign bus.at_zero = (r_q == L_ZERO);

endmodule
